pifo_task_dispatch: RTL and testbench
=====================================

Name: pifo_task_dispatch

Overview:
- Parametrised ingress stage for the virtualised PIFO tree.
- Buffers push/pop tasks from NPORT host ports in per-port task FIFOs.
- Arbitrates each FIFO head onto the root RPU of its tree, where root RPU = tree_id mod LEVEL.
- Successor to the fixed 4-port TaskFIFO/TaskDistribute pair: decouples port count from LEVEL, supports merged push+pop tasks, and adds RPU back-pressure and issue pacing.

Parameters:
- PTW, 16, payload width per task.
- TREE_NUM, 4, number of virtual trees.
- LEVEL, 4, number of RPUs; power of 2, ≥2.
- NPORT, 4, number of host ports, 1..16.
- FIFO_DEPTH, 8, entries per port FIFO; power of 2.
- ISSUE_GAP, 1, minimum cycles between two issues to the same RPU, 1..15.

Ports:
- i_clk, in, 1, clock.
- i_arst_n, in, 1, asynchronous active-low reset.
- i_push, in, NPORT, per-port push request.
- i_pop, in, NPORT, per-port pop request.
- i_tree_id, in, NPORT*clog2(TREE_NUM), per-port tree id; port p occupies slice p.
- i_push_data, in, NPORT*PTW, per-port push payload.
- o_full, out, NPORT, port FIFO holds FIFO_DEPTH entries.
- o_drop, out, NPORT, one-cycle pulse: task rejected because FIFO was full.
- o_fifo_count, out, NPORT*(clog2(FIFO_DEPTH)+1), per-port occupancy.
- i_rpu_ready, in, LEVEL, RPU r can accept a task this cycle.
- o_rpu_push, out, LEVEL, registered push to RPU r.
- o_rpu_pop, out, LEVEL, registered pop to RPU r.
- o_rpu_tree_id, out, LEVEL*clog2(TREE_NUM), tree id for the RPU r op.
- o_rpu_push_data, out, LEVEL*PTW, payload for the RPU r op; all-ones when no push.

Behaviour:
- Reset (asynchronous, active-low), mid-operation included: all FIFOs emptied; count, pointers and pacing counters cleared to 0. Output reset values: o_rpu_push=0, o_rpu_pop=0, o_rpu_tree_id=0, o_rpu_push_data=all-ones, o_full=0, o_drop=0, o_fifo_count=0. Tasks in flight are lost.
- Enqueue: on any cycle with i_push[p] or i_pop[p], one entry {op[1:0], tree_id, data} is written to FIFO p.
  - op encodings: 01 = push, 10 = pop, 11 = push+pop. Data field is 0 for pop-only.
  - Push+pop on the same port is one merged entry, not discarded.
- Full handling: an entry is accepted if count<FIFO_DEPTH, or if FIFO p is dequeued in the same cycle. Otherwise it is dropped and o_drop[p]=1 on the next cycle.
- o_full[p] is (count==FIFO_DEPTH). Count wraps never: accepted writes are bounded by the rule above.
- Candidate rule: port p is a candidate for RPU r when FIFO p is non-empty and head.tree_id & (LEVEL-1) == r.
- Grant rule: RPU r grants one candidate per cycle, only if i_rpu_ready[r]=1 and pace_cnt[r]==0.
- Arbitration: per-RPU round-robin pointer rr[r]. Search starts at rr[r]; after a grant rr[r] = granted port + 1 mod NPORT. rr[r] holds when there is no grant.
- A port's head targets only one RPU, so a port is granted at most once per cycle. A granted head is dequeued on that clock edge.
- Issue: the cycle after a grant, o_rpu_push[r]=op[0], o_rpu_pop[r]=op[1], with tree_id and data from the entry. All of these are 0 / all-ones in cycles with no issue.
- Pacing: on a grant, pace_cnt[r] loads ISSUE_GAP-1, then decrements to 0. ISSUE_GAP=1 allows back-to-back issue.
- Latency: with an empty FIFO, ready RPU and no contention, i_push in cycle t produces o_rpu_push in cycle t+2.
- Ordering: order within a port is strictly FIFO. There is no ordering across ports.
- i_rpu_ready low stalls only RPU r. Other RPUs continue, and a blocked head blocks its own port (head-of-line blocking is intended).

Optional Feature:
- DISPATCH_STRICT_PRIO_EN defined: round-robin is replaced by fixed priority, lowest port index wins. rr pointers are not built.
- Not defined: round-robin as above.

Test Plan:
- Single task: reset, then port 0 push tree_id=2, data=0x1234 at cycle 5. Expect o_rpu_push[2]=1, data=0x1234, tree_id=2 in cycle 7 only; o_fifo_count[0] reads 1 in cycle 6 and 0 in cycle 7.
- Merged op: port 1 asserts push+pop with tree_id=3, data=0xAAAA. Expect o_rpu_push[3]=1 and o_rpu_pop[3]=1 in the same cycle; o_drop stays 0.
- Contention: ports 0..3 each enqueue 2 pushes to tree 1 in the same cycle. Expect issues on RPU 1 on 8 consecutive cycles in port order 0,1,2,3,0,1,2,3. With DISPATCH_STRICT_PRIO_EN, expect order 0,0,1,1,2,2,3,3.
- Overflow: i_rpu_ready=0, 9 pushes to port 0. Expect o_full[0]=1 after the 8th push and an o_drop[0] pulse for the 9th. Raise ready: 8 pushes issue in order.
- Pacing: ISSUE_GAP=3, 3 tasks to tree 0 on port 0. Expect issues exactly 3 cycles apart.
- Reset mid-operation: reset asserted with 5 entries queued. All outputs go to reset values immediately; after release there are no issues and o_fifo_count is all 0.

Source files
------------

// File: rtl/pifo_task_dispatch_if.sv
// Host-port and RPU-side signal bundle for pifo_task_dispatch.
// Host ports push/pop into per-port FIFOs; the RPU side carries the issued ops.
// The RPU side is throttled per RPU by i_rpu_ready.
interface pifo_task_dispatch_if #(
    parameter int PTW        = 16,
    parameter int TREE_NUM   = 4,
    parameter int LEVEL      = 4,
    parameter int NPORT      = 4,
    parameter int FIFO_DEPTH = 8
);
    localparam int TIDW = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;

    logic [NPORT-1:0]      i_push;
    logic [NPORT-1:0]      i_pop;
    logic [NPORT*TIDW-1:0] i_tree_id;
    logic [NPORT*PTW-1:0]  i_push_data;
    logic [NPORT-1:0]      o_full;
    logic [NPORT-1:0]      o_drop;
    logic [NPORT*CW-1:0]   o_fifo_count;
    logic [LEVEL-1:0]      i_rpu_ready;
    logic [LEVEL-1:0]      o_rpu_push;
    logic [LEVEL-1:0]      o_rpu_pop;
    logic [LEVEL*TIDW-1:0] o_rpu_tree_id;
    logic [LEVEL*PTW-1:0]  o_rpu_push_data;

    modport master (
        output i_push, i_pop, i_tree_id, i_push_data, i_rpu_ready,
        input  o_full, o_drop, o_fifo_count,
        input  o_rpu_push, o_rpu_pop, o_rpu_tree_id, o_rpu_push_data
    );

    modport slave (
        input  i_push, i_pop, i_tree_id, i_push_data, i_rpu_ready,
        output o_full, o_drop, o_fifo_count,
        output o_rpu_push, o_rpu_pop, o_rpu_tree_id, o_rpu_push_data
    );
endinterface

// File: rtl/fifo.sv
// Generic synchronous FIFO with occupancy count.
// Latency: a write is visible at rd_dat the cycle after it is accepted.
// Backpressure: a write is refused when full unless a read happens in the same cycle.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                   core_clk,
    input  logic                   arst_n,
    input  logic                   wr_vld,
    input  logic [W-1:0]           wr_dat,
    output logic                   wr_acc,
    input  logic                   rd_rdy,
    output logic                   rd_vld,
    output logic [W-1:0]           rd_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rd_fire;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rd_vld  = (count != '0);
    assign rd_fire = rd_rdy && rd_vld;
    assign wr_acc  = wr_vld && ((count != CW'(DEPTH)) || rd_fire);
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc)  wr_ptr <= ptr_inc(wr_ptr);
            if (rd_fire) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_acc, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: emptiness is carried entirely by the pointers and count.
    always_ff @(posedge core_clk) begin
        if (wr_acc) mem[wr_ptr] <= wr_dat;
    end
endmodule

// File: rtl/pifo_task_dispatch.sv
// PIFO ingress: per-port task FIFOs arbitrated onto root RPU (tree_id mod LEVEL); DISPATCH_STRICT_PRIO_EN selects fixed priority.
// Latency: push into an idle path reaches the RPU outputs two cycles later (FIFO write, then registered issue).
// Backpressure: i_rpu_ready and ISSUE_GAP pacing stall a single RPU; full FIFOs drop with a one-cycle o_drop pulse.
module pifo_task_dispatch #(
    parameter int PTW        = 16,
    parameter int TREE_NUM   = 4,
    parameter int LEVEL      = 4,
    parameter int NPORT      = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int ISSUE_GAP  = 1
) (
    input logic               i_clk,
    input logic               i_arst_n,
    pifo_task_dispatch_if.slave bus
);
    localparam int TIDW = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1;
    localparam int LW   = $clog2(LEVEL);
    localparam int PW   = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] GAP_LD = 4'(ISSUE_GAP - 1);

    typedef struct packed {
        logic [1:0]      op;
        logic [TIDW-1:0] tree_id;
        logic [PTW-1:0]  data;
    } task_t;

    logic [NPORT-1:0]         wr_req;
    logic [NPORT-1:0]         wr_acc;
    logic [NPORT-1:0]         head_vld;
    logic [NPORT-1:0]         deq;
    logic [NPORT-1:0]         drop_q;
    task_t [NPORT-1:0]        heads;
    logic [NPORT-1:0][LW-1:0] head_rpu;

    logic [LEVEL-1:0]           gnt_vld;
    logic [LEVEL-1:0][PW-1:0]   gnt_port;
    task_t [LEVEL-1:0]          gnt_task;
    logic [LEVEL-1:0][3:0]      pace_cnt;
    logic [LEVEL-1:0]           rpu_push;
    logic [LEVEL-1:0]           rpu_pop;
    logic [LEVEL-1:0][TIDW-1:0] rpu_tid;
    logic [LEVEL-1:0][PTW-1:0]  rpu_data;

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        task_t         wtask;
        task_t         hd;
        logic [CW-1:0] cnt;

        assign wr_req[p] = bus.i_push[p] | bus.i_pop[p];

        // Push and pop on one port merge into a single entry; pop-only carries zero data.
        always_comb begin
            wtask         = '0;
            wtask.op      = {bus.i_pop[p], bus.i_push[p]};
            wtask.tree_id = bus.i_tree_id[p*TIDW +: TIDW];
            wtask.data    = bus.i_push[p] ? bus.i_push_data[p*PTW +: PTW] : '0;
        end

        fifo #(
            .W     ($bits(task_t)),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .core_clk (i_clk),
            .arst_n   (i_arst_n),
            .wr_vld   (wr_req[p]),
            .wr_dat   (wtask),
            .wr_acc   (wr_acc[p]),
            .rd_rdy   (deq[p]),
            .rd_vld   (head_vld[p]),
            .rd_dat   (hd),
            .count    (cnt)
        );

        assign heads[p]                      = hd;
        assign head_rpu[p]                   = LW'(hd.tree_id);
        assign bus.o_fifo_count[p*CW +: CW]  = cnt;
        assign bus.o_full[p]                 = (cnt == CW'(FIFO_DEPTH));
    end

`ifndef DISPATCH_STRICT_PRIO_EN
    logic [LEVEL-1:0][PW-1:0] rr;
`endif

    // Per-RPU arbitration; each head maps to exactly one RPU, so no port is granted twice.
    always_comb begin : p_arb
        int idx;
        idx      = 0;
        gnt_vld  = '0;
        gnt_port = '0;
        gnt_task = '0;
        for (int r = 0; r < LEVEL; r++) begin
            if (bus.i_rpu_ready[r] && (pace_cnt[r] == 4'd0)) begin
                for (int k = 0; k < NPORT; k++) begin
`ifdef DISPATCH_STRICT_PRIO_EN
                    idx = k;
`else
                    idx = (int'(rr[r]) + k) % NPORT;
`endif
                    if (!gnt_vld[r] && head_vld[PW'(idx)] && (head_rpu[PW'(idx)] == LW'(r))) begin
                        gnt_vld[r]  = 1'b1;
                        gnt_port[r] = PW'(idx);
                        gnt_task[r] = heads[PW'(idx)];
                    end
                end
            end
        end
    end

    always_comb begin
        deq = '0;
        for (int r = 0; r < LEVEL; r++) begin
            if (gnt_vld[r]) deq[gnt_port[r]] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            rpu_push <= '0;
            rpu_pop  <= '0;
            rpu_tid  <= '0;
            rpu_data <= '1;
            pace_cnt <= '0;
            drop_q   <= '0;
        end else begin
            drop_q <= wr_req & ~wr_acc;
            for (int r = 0; r < LEVEL; r++) begin
                rpu_push[r] <= gnt_vld[r] & gnt_task[r].op[0];
                rpu_pop[r]  <= gnt_vld[r] & gnt_task[r].op[1];
                rpu_tid[r]  <= gnt_vld[r] ? gnt_task[r].tree_id : '0;
                rpu_data[r] <= (gnt_vld[r] && gnt_task[r].op[0]) ? gnt_task[r].data : '1;
                if (gnt_vld[r])
                    pace_cnt[r] <= GAP_LD;
                else if (pace_cnt[r] != 4'd0)
                    pace_cnt[r] <= pace_cnt[r] - 4'd1;
            end
        end
    end

`ifndef DISPATCH_STRICT_PRIO_EN
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            rr <= '0;
        end else begin
            for (int r = 0; r < LEVEL; r++) begin
                if (gnt_vld[r])
                    rr[r] <= (gnt_port[r] == PW'(NPORT - 1)) ? '0 : gnt_port[r] + 1'b1;
            end
        end
    end
`endif

    assign bus.o_drop          = drop_q;
    assign bus.o_rpu_push      = rpu_push;
    assign bus.o_rpu_pop       = rpu_pop;
    assign bus.o_rpu_tree_id   = rpu_tid;
    assign bus.o_rpu_push_data = rpu_data;
endmodule

// File: tb/tb_pifo_task_dispatch.sv
// Directed bench for pifo_task_dispatch: a default instance plus an ISSUE_GAP=3 instance for pacing.
module tb_pifo_task_dispatch;
    localparam int PTW = 16, TREE_NUM = 4, LEVEL = 4, NPORT = 4, FIFO_DEPTH = 8;

    logic clk    = 1'b0;
    logic arst_n = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pifo_task_dispatch_if #(.PTW(PTW), .TREE_NUM(TREE_NUM), .LEVEL(LEVEL), .NPORT(NPORT),
                            .FIFO_DEPTH(FIFO_DEPTH)) bus ();
    pifo_task_dispatch_if #(.PTW(PTW), .TREE_NUM(TREE_NUM), .LEVEL(LEVEL), .NPORT(NPORT),
                            .FIFO_DEPTH(FIFO_DEPTH)) bus_g3 ();

    pifo_task_dispatch #(.PTW(PTW), .TREE_NUM(TREE_NUM), .LEVEL(LEVEL), .NPORT(NPORT),
                         .FIFO_DEPTH(FIFO_DEPTH), .ISSUE_GAP(1)) u_dut (
        .i_clk    (clk),
        .i_arst_n (arst_n),
        .bus      (bus.slave)
    );

    pifo_task_dispatch #(.PTW(PTW), .TREE_NUM(TREE_NUM), .LEVEL(LEVEL), .NPORT(NPORT),
                         .FIFO_DEPTH(FIFO_DEPTH), .ISSUE_GAP(3)) u_dut_gap (
        .i_clk    (clk),
        .i_arst_n (arst_n),
        .bus      (bus_g3.slave)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_push      = '0;
        bus.i_pop       = '0;
        bus.i_tree_id   = '0;
        bus.i_push_data = '0;
    endtask

    task automatic set_port(input int p, input logic ps, input logic pp,
                            input logic [1:0] tid, input logic [15:0] d);
        bus.i_push[p]              = ps;
        bus.i_pop[p]               = pp;
        bus.i_tree_id[p*2 +: 2]    = tid;
        bus.i_push_data[p*16 +: 16] = d;
    endtask

    function automatic logic [15:0] data_of(input int r);
        return bus.o_rpu_push_data[r*16 +: 16];
    endfunction

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_push"},  bus.o_rpu_push, 0);
        chk({pfx, "_pop"},   bus.o_rpu_pop, 0);
        chk({pfx, "_tid"},   bus.o_rpu_tree_id, 0);
        chk({pfx, "_data"},  bus.o_rpu_push_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk({pfx, "_full"},  bus.o_full, 0);
        chk({pfx, "_drop"},  bus.o_drop, 0);
        chk({pfx, "_count"}, bus.o_fifo_count, 0);
    endtask

    initial begin
        int t_iss [4];
        logic [15:0] d_iss [4];
        int n_iss;
        int ep;
        int ei;

        idle();
        bus.i_rpu_ready    = '1;
        bus_g3.i_push      = '0;
        bus_g3.i_pop       = '0;
        bus_g3.i_tree_id   = '0;
        bus_g3.i_push_data = '0;
        bus_g3.i_rpu_ready = '1;

        repeat (2) step();
        chk_reset_outputs("reset");
        arst_n = 1'b1;
        repeat (2) step();

        // Single push: count 1 next cycle, issue on RPU 2 the cycle after, exactly once.
        set_port(0, 1'b1, 1'b0, 2'd2, 16'h1234);
        step();
        idle();
        chk("t1_count_t1", bus.o_fifo_count[3:0], 1);
        chk("t1_nopush_t1", bus.o_rpu_push, 0);
        step();
        chk("t1_push_t2", bus.o_rpu_push, 4'b0100);
        chk("t1_pop_t2", bus.o_rpu_pop, 0);
        chk("t1_data_t2", data_of(2), 16'h1234);
        chk("t1_tid_t2", bus.o_rpu_tree_id[5:4], 2);
        chk("t1_count_t2", bus.o_fifo_count[3:0], 0);
        step();
        chk("t1_once", bus.o_rpu_push, 0);

        // Merged push+pop on port 1 to tree 3.
        set_port(1, 1'b1, 1'b1, 2'd3, 16'hAAAA);
        step();
        idle();
        chk("t2_drop_t1", bus.o_drop, 0);
        step();
        chk("t2_push", bus.o_rpu_push, 4'b1000);
        chk("t2_pop", bus.o_rpu_pop, 4'b1000);
        chk("t2_data", data_of(3), 16'hAAAA);
        chk("t2_drop_t2", bus.o_drop, 0);
        step();

        // Pop-only: no push, data lane stays all-ones.
        set_port(2, 1'b0, 1'b1, 2'd2, 16'h5555);
        step();
        idle();
        step();
        chk("pop_only_pop", bus.o_rpu_pop, 4'b0100);
        chk("pop_only_push", bus.o_rpu_push, 0);
        chk("pop_only_data", data_of(2), 16'hFFFF);
        step();

        // Contention: four ports, two pushes each, all to tree 1.
        for (int p = 0; p < NPORT; p++) set_port(p, 1'b1, 1'b0, 2'd1, 16'hC000 | 16'(p << 4));
        step();
        for (int p = 0; p < NPORT; p++) set_port(p, 1'b1, 1'b0, 2'd1, 16'hC001 | 16'(p << 4));
        step();
        idle();
        for (int i = 0; i < 8; i++) begin
`ifdef DISPATCH_STRICT_PRIO_EN
            ep = i / 2;
            ei = i % 2;
`else
            ep = i % 4;
            ei = i / 4;
`endif
            chk("cont_vld", bus.o_rpu_push, 4'b0010);
            chk("cont_order", data_of(1), 16'hC000 | 16'(ep << 4) | 16'(ei));
            step();
        end
        chk("cont_done", bus.o_rpu_push, 0);

        // Overflow: RPU 0 blocked, nine pushes to port 0.
        bus.i_rpu_ready = 4'b1110;
        for (int k = 0; k < 9; k++) begin
            set_port(0, 1'b1, 1'b0, 2'd0, (k < 8) ? 16'h5000 + 16'(k) : 16'h5EEE);
            step();
            if (k == 6) chk("ovf_notfull_7", bus.o_full[0], 0);
            if (k == 7) begin
                chk("ovf_full_8", bus.o_full[0], 1);
                chk("ovf_count_8", bus.o_fifo_count[3:0], 8);
                chk("ovf_nodrop_8", bus.o_drop[0], 0);
            end
            if (k == 8) begin
                chk("ovf_drop_9", bus.o_drop, 4'b0001);
                chk("ovf_count_9", bus.o_fifo_count[3:0], 8);
            end
        end
        // Ready returns with one more push: accepted because the head dequeues the same cycle.
        bus.i_rpu_ready = 4'b1111;
        set_port(0, 1'b1, 1'b0, 2'd0, 16'h5008);
        step();
        idle();
        chk("ovf_accept_on_deq", bus.o_drop, 0);
        chk("ovf_count_hold", bus.o_fifo_count[3:0], 8);
        for (int k = 0; k < 9; k++) begin
            chk("ovf_drain_vld", bus.o_rpu_push, 4'b0001);
            chk("ovf_drain_data", data_of(0), 16'h5000 + 16'(k));
            step();
        end
        chk("ovf_drain_done", bus.o_rpu_push, 0);
        chk("ovf_drain_empty", bus.o_fifo_count[3:0], 0);

        // Pacing on the ISSUE_GAP=3 instance.
        n_iss = 0;
        for (int c = 0; c < 14; c++) begin
            bus_g3.i_push[0]          = (c < 3);
            bus_g3.i_tree_id[1:0]     = 2'd0;
            bus_g3.i_push_data[15:0]  = 16'h6000 + 16'(c);
            step();
            if (bus_g3.o_rpu_push[0]) begin
                if (n_iss < 4) begin
                    t_iss[n_iss] = c + 1;
                    d_iss[n_iss] = bus_g3.o_rpu_push_data[15:0];
                end
                n_iss++;
            end
        end
        bus_g3.i_push = '0;
        chk("gap_n", n_iss, 3);
        chk("gap_t0", t_iss[0], 2);
        chk("gap_t1", t_iss[1], 5);
        chk("gap_t2", t_iss[2], 8);
        chk("gap_d0", d_iss[0], 16'h6000);
        chk("gap_d2", d_iss[2], 16'h6002);

        // Reset mid-operation with five entries queued behind a blocked RPU 0.
        bus.i_rpu_ready = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            set_port(0, 1'b1, 1'b0, 2'd0, 16'h7000 + 16'(k));
            if (k == 4) set_port(1, 1'b1, 1'b0, 2'd1, 16'h7777);
            step();
        end
        idle();
        step();
        chk("mid_count", bus.o_fifo_count[3:0], 5);
        chk("mid_push", bus.o_rpu_push, 4'b0010);
        #2;
        arst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        repeat (2) step();
        arst_n = 1'b1;
        bus.i_rpu_ready = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_quiet", {bus.o_rpu_push, bus.o_rpu_pop}, 0);
        end
        chk("post_rst_count", bus.o_fifo_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
